busdebugger_command_rx: RTL and testbench
=========================================

BUSDEBUGGER_COMMAND_RX -- requirements
Module: busdebugger_command_rx

Interface
REQ-001 The module SHALL have one parameter: CMD_TIMEOUT, default 4096, the number of idle serial_clock cycles after which a partial multi-byte command is abandoned.
REQ-002 The port list SHALL be as follows, clock and reset first:
- serial_clock  in  1  sole clock.
- reset  in  1  asynchronous, active-low.
- clocks_per_bit  in  12  serial_clock cycles per UART bit; held stable in operation; minimum value 4.
- pin_usart_rx  in  1  raw UART line; idles high.
- dump_start  out  1  one-cycle pulse requesting a dump.
- record_start  out  1  one-cycle pulse arming recording.
- trigger_addr  out  32  programmed trigger address.
- trigger_enable  out  1  level; trigger comparison enabled.
- frame_error  out  1  one-cycle pulse on a bad stop bit.
- cmd_error  out  1  one-cycle pulse on an unknown opcode or a timeout.
- led  out  1  toggles on every accepted command.

Function
REQ-003 pin_usart_rx SHALL pass through a two-flop synchronizer with both flops reset to 1; all receiver logic SHALL use only the synchronized value.
REQ-004 The receiver FSM SHALL have the states RX_IDLE, RX_START, RX_DATA and RX_STOP, with a 12-bit bit counter and a 3-bit bit index.
REQ-005 In RX_IDLE, a synchronized low SHALL load the counter with clocks_per_bit>>1 and move to RX_START.
REQ-006 RX_START SHALL behave as follows when the counter expires:
- line still low: move to RX_DATA with the counter loaded to clocks_per_bit.
- line high: treat as a glitch and return to RX_IDLE with no output.
REQ-007 RX_DATA SHALL sample one bit each time the counter expires, 8 bits LSB-first, reloading clocks_per_bit after each sample, then move to RX_STOP.
REQ-008 RX_STOP SHALL sample the stop bit one clocks_per_bit later and then return to RX_IDLE:
- stop bit 1: assert an internal byte_valid for exactly one cycle with the byte.
- stop bit 0: pulse frame_error, discard the byte and force the parser to P_CMD.
REQ-009 End-to-end latency SHALL be at most 4 serial_clock cycles from the stop-bit sample to the resulting output pulse; no byte SHALL be dropped at continuous line rate.
REQ-010 The parser FSM SHALL have the states P_CMD and P_ADDR, with a 2-bit byte counter and a 32-bit shift register.
REQ-011 In P_CMD, the parser SHALL act on the received byte as follows:
- 0x44 'D': pulse dump_start.
- 0x52 'R': pulse record_start.
- 0x43 'C': clear trigger_enable.
- 0x54 'T': clear the byte counter and move to P_ADDR.
- any other byte: pulse cmd_error.
REQ-012 In P_ADDR, each byte SHALL shift into the shift register MSB-first (big-endian).
REQ-013 On the 4th address byte, the parser SHALL:
- update trigger_addr from the shift register in the same cycle.
- set trigger_enable to 1.
- return to P_CMD.
REQ-014 trigger_addr SHALL change only on completion of a 'T' command; a partial address SHALL never be visible.
REQ-015 An idle counter SHALL count cycles spent in P_ADDR without byte_valid; on reaching CMD_TIMEOUT it SHALL pulse cmd_error, discard the partial address and return to P_CMD.
REQ-016 Each byte_valid in P_ADDR SHALL reset the idle counter to 0.
REQ-017 The led output SHALL toggle when a 'D', 'R' or 'C' command is accepted and when a 'T' command completes; it SHALL NOT toggle on errors.
REQ-018 dump_start, record_start, frame_error and cmd_error SHALL each be asserted for exactly one cycle per event and SHALL never be asserted on consecutive cycles.
REQ-019 If a frame_error occurs during P_ADDR, only frame_error SHALL pulse; cmd_error SHALL NOT pulse, and the partial address SHALL be discarded.
REQ-020 A change of clocks_per_bit in the middle of a byte SHALL NOT be required to produce a correct byte, but SHALL NOT lock up the receiver FSM.

Reset
REQ-021 While reset=0, the module SHALL hold the following values:
- receiver in RX_IDLE, parser in P_CMD, all counters at 0, synchronizer flops at 1.
- trigger_addr = 0x00000000, trigger_enable = 0, led = 0.
- all pulse outputs = 0.
REQ-022 Reset asserted in the middle of a frame or command SHALL abandon it, with no output pulse produced on release.
REQ-023 The first byte whose start edge falls at least 2 cycles after reset release SHALL be received correctly.

Verification
REQ-024 The bench SHALL cover the following directed scenarios, all with clocks_per_bit=32:
- 'D' (0x44) sent: dump_start high for exactly 1 cycle within 4 cycles of the stop-bit sample; no other pulse; led=1.
- bytes 0x54,0x12,0x34,0x56,0x78 sent back-to-back: trigger_addr=0x12345678 and trigger_enable=1 after the 5th stop bit; trigger_addr unchanged before that; then 'C' sent: trigger_enable=0 with trigger_addr retained.
- 0x44 sent with a stop bit of 0: frame_error pulses once; dump_start stays 0.
- low glitch of 10 cycles on the idle line: no pulse and no state change; a following 'R' produces record_start.
- 0x54,0xAA followed by CMD_TIMEOUT idle cycles: cmd_error pulses once; a following 'D' produces dump_start and trigger_addr stays 0.
- reset asserted mid-way through the 3rd address byte of a 'T' command: trigger_addr=0 and trigger_enable=0; the remaining bits on the line cause no pulse.

Source files
------------

// File: rtl/busdebugger_command_rx.sv
// UART command receiver for the bus debugger: oversampled 8N1 receiver
// feeding a small opcode parser (D/R/C/T) that drives dump/record pulses,
// the trigger address and the activity led.
//
// state    | meaning
// RX_IDLE  | line idle, waiting for a low on the synchronized input
// RX_START | half a bit into a possible start bit, confirming it is still low
// RX_DATA  | sampling 8 data bits LSB-first, one per bit period
// RX_STOP  | waiting one bit period to sample the stop bit
// P_CMD    | next byte is an opcode
// P_ADDR   | collecting the 4 big-endian address bytes of a 'T' command
module busdebugger_command_rx #(
  parameter int CMD_TIMEOUT = 4096
) (
  input  logic        serial_clock,
  input  logic        reset,
  input  logic [11:0] clocks_per_bit,
  input  logic        pin_usart_rx,
  output logic        dump_start,
  output logic        record_start,
  output logic [31:0] trigger_addr,
  output logic        trigger_enable,
  output logic        frame_error,
  output logic        cmd_error,
  output logic        led
);

  localparam int IW = $clog2(CMD_TIMEOUT + 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic {P_CMD, P_ADDR} p_state_t;

  logic        rx_meta, rx_sync;
  rx_state_t   rx_state, rx_state_nxt;
  logic [11:0] bit_cnt, bit_cnt_nxt;
  logic [2:0]  bit_idx, bit_idx_nxt;
  logic [7:0]  rx_shift, rx_shift_nxt;
  logic        byte_valid, byte_valid_nxt, frame_err_nxt;
  logic        bit_tick;

  p_state_t    p_state, p_state_nxt;
  logic [1:0]  byte_cnt, byte_cnt_nxt;
  logic [31:0] addr_shift, addr_shift_nxt, trigger_addr_nxt;
  logic [IW-1:0] idle_cnt, idle_cnt_nxt;
  logic        trig_en_nxt, led_nxt, dump_nxt, rec_nxt, cmd_err_nxt;

  // The counter expires at 1 so a load of N spans exactly N cycles; a value
  // of 0 (possible if clocks_per_bit changes mid-frame) also counts as
  // expired so the receiver can never stall.
  assign bit_tick = (bit_cnt <= 12'd1);

  // Two-flop synchronizer for the raw line, idling high.
  always_ff @(posedge serial_clock or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= pin_usart_rx;
      rx_sync <= rx_meta;
    end
  end

  // Receiver next-state: start confirmation, data sampling, stop check.
  always_comb begin
    rx_state_nxt   = rx_state;
    bit_cnt_nxt    = bit_tick ? 12'd0 : bit_cnt - 12'd1;
    bit_idx_nxt    = bit_idx;
    rx_shift_nxt   = rx_shift;
    byte_valid_nxt = 1'b0;
    frame_err_nxt  = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (!rx_sync) begin
          rx_state_nxt = RX_START;
          bit_cnt_nxt  = {1'b0, clocks_per_bit[11:1]};
        end
      end
      RX_START: begin
        if (bit_tick) begin
          if (!rx_sync) begin
            rx_state_nxt = RX_DATA;
            bit_cnt_nxt  = clocks_per_bit;
            bit_idx_nxt  = 3'd0;
          end else begin
            rx_state_nxt = RX_IDLE;
          end
        end
      end
      RX_DATA: begin
        if (bit_tick) begin
          rx_shift_nxt = {rx_sync, rx_shift[7:1]};
          bit_cnt_nxt  = clocks_per_bit;
          bit_idx_nxt  = bit_idx + 3'd1;
          if (bit_idx == 3'd7) rx_state_nxt = RX_STOP;
        end
      end
      RX_STOP: begin
        if (bit_tick) begin
          rx_state_nxt   = RX_IDLE;
          byte_valid_nxt = rx_sync;
          frame_err_nxt  = !rx_sync;
        end
      end
      default: rx_state_nxt = RX_IDLE;
    endcase
  end

  // Receiver state register.
  always_ff @(posedge serial_clock or negedge reset) begin
    if (!reset) begin
      rx_state    <= RX_IDLE;
      bit_cnt     <= 12'd0;
      bit_idx     <= 3'd0;
      rx_shift    <= 8'h00;
      byte_valid  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      rx_state    <= rx_state_nxt;
      bit_cnt     <= bit_cnt_nxt;
      bit_idx     <= bit_idx_nxt;
      rx_shift    <= rx_shift_nxt;
      byte_valid  <= byte_valid_nxt;
      frame_error <= frame_err_nxt;
    end
  end

  // Parser next-state: opcode decode, address collection and idle timeout.
  // rx_shift holds the byte stable in the cycle byte_valid is high.
  always_comb begin
    p_state_nxt      = p_state;
    byte_cnt_nxt     = byte_cnt;
    addr_shift_nxt   = addr_shift;
    trigger_addr_nxt = trigger_addr;
    idle_cnt_nxt     = idle_cnt;
    trig_en_nxt      = trigger_enable;
    led_nxt          = led;
    dump_nxt         = 1'b0;
    rec_nxt          = 1'b0;
    cmd_err_nxt      = 1'b0;
    case (p_state)
      P_CMD: begin
        idle_cnt_nxt = '0;
        if (byte_valid) begin
          case (rx_shift)
            8'h44: begin dump_nxt = 1'b1; led_nxt = ~led; end
            8'h52: begin rec_nxt = 1'b1; led_nxt = ~led; end
            8'h43: begin trig_en_nxt = 1'b0; led_nxt = ~led; end
            8'h54: begin
              byte_cnt_nxt   = 2'd0;
              addr_shift_nxt = 32'h0;
              p_state_nxt    = P_ADDR;
            end
            default: cmd_err_nxt = 1'b1;
          endcase
        end
      end
      P_ADDR: begin
        if (frame_error) begin
          p_state_nxt  = P_CMD;
          idle_cnt_nxt = '0;
        end else if (byte_valid) begin
          idle_cnt_nxt   = '0;
          addr_shift_nxt = {addr_shift[23:0], rx_shift};
          byte_cnt_nxt   = byte_cnt + 2'd1;
          if (byte_cnt == 2'd3) begin
            trigger_addr_nxt = {addr_shift[23:0], rx_shift};
            trig_en_nxt      = 1'b1;
            led_nxt          = ~led;
            p_state_nxt      = P_CMD;
          end
        end else if (idle_cnt == IW'(CMD_TIMEOUT - 1)) begin
          cmd_err_nxt  = 1'b1;
          idle_cnt_nxt = '0;
          p_state_nxt  = P_CMD;
        end else begin
          idle_cnt_nxt = idle_cnt + IW'(1);
        end
      end
      default: p_state_nxt = P_CMD;
    endcase
  end

  // Parser state and output registers. A timeout immediately followed by an
  // unknown opcode merges into a single cmd_error pulse.
  always_ff @(posedge serial_clock or negedge reset) begin
    if (!reset) begin
      p_state        <= P_CMD;
      byte_cnt       <= 2'd0;
      addr_shift     <= 32'h0;
      idle_cnt       <= '0;
      trigger_addr   <= 32'h0;
      trigger_enable <= 1'b0;
      led            <= 1'b0;
      dump_start     <= 1'b0;
      record_start   <= 1'b0;
      cmd_error      <= 1'b0;
    end else begin
      p_state        <= p_state_nxt;
      byte_cnt       <= byte_cnt_nxt;
      addr_shift     <= addr_shift_nxt;
      idle_cnt       <= idle_cnt_nxt;
      trigger_addr   <= trigger_addr_nxt;
      trigger_enable <= trig_en_nxt;
      led            <= led_nxt;
      dump_start     <= dump_nxt;
      record_start   <= rec_nxt;
      cmd_error      <= cmd_err_nxt & ~cmd_error;
    end
  end

endmodule

// File: tb/tb_busdebugger_command_rx.sv
// Bench for busdebugger_command_rx: drives UART frames at 32 clocks per bit,
// predicts every output pulse and level from a byte-level command model.
module tb_busdebugger_command_rx;

  localparam int CPB = 32;
  localparam int TMO = 4096;
  localparam logic [3:0] K_NONE = 4'b0000;
  localparam logic [3:0] K_DUMP = 4'b1000;
  localparam logic [3:0] K_REC  = 4'b0100;
  localparam logic [3:0] K_FERR = 4'b0010;
  localparam logic [3:0] K_CERR = 4'b0001;

  logic        serial_clock = 1'b0;
  logic        reset = 1'b0;
  logic [11:0] clocks_per_bit = 12'd32;
  logic        pin_usart_rx = 1'b1;
  logic        dump_start, record_start, trigger_enable, frame_error, cmd_error, led;
  logic [31:0] trigger_addr;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_mid = 0;

  busdebugger_command_rx #(.CMD_TIMEOUT(TMO)) dut (
    .serial_clock  (serial_clock),
    .reset         (reset),
    .clocks_per_bit(clocks_per_bit),
    .pin_usart_rx  (pin_usart_rx),
    .dump_start    (dump_start),
    .record_start  (record_start),
    .trigger_addr  (trigger_addr),
    .trigger_enable(trigger_enable),
    .frame_error   (frame_error),
    .cmd_error     (cmd_error),
    .led           (led)
  );

  always #5 serial_clock = ~serial_clock;
  always @(posedge serial_clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected-event windows: each holds the pulse that must appear in
  // [lo, hi] and the output levels that hold once it has passed.
  typedef struct {
    int          lo;
    int          hi;
    logic [3:0]  mask;
    logic [31:0] addr;
    logic        en;
    logic        led;
  } win_t;

  win_t        win_q[$];
  logic [7:0]  m_bytes[$];
  logic [31:0] m_addr = 32'h0;
  logic        m_en = 1'b0;
  logic        m_led = 1'b0;
  bit          m_in_addr = 1'b0;
  logic [31:0] c_addr = 32'h0;
  logic        c_en = 1'b0;
  logic        c_led = 1'b0;
  int          win_hits = 0;

  function automatic void push_win(input int lo, input logic [3:0] k);
    win_t w;
    w.lo = lo; w.hi = lo + 7; w.mask = k;
    w.addr = m_addr; w.en = m_en; w.led = m_led;
    win_q.push_back(w);
  endfunction

  // Command semantics at byte granularity; mid is the line-side centre of
  // the stop bit.
  function automatic void model_byte(input logic [7:0] b, input bit stop_ok, input int mid);
    logic [3:0] k;
    k = K_NONE;
    if (!stop_ok) begin
      k = K_FERR;
      m_in_addr = 1'b0;
      m_bytes.delete();
    end else if (m_in_addr) begin
      m_bytes.push_back(b);
      if (m_bytes.size() == 4) begin
        m_addr = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
        m_en = 1'b1;
        m_led = ~m_led;
        m_in_addr = 1'b0;
        m_bytes.delete();
      end
    end else if (b == 8'h44) begin
      k = K_DUMP; m_led = ~m_led;
    end else if (b == 8'h52) begin
      k = K_REC; m_led = ~m_led;
    end else if (b == 8'h43) begin
      m_en = 1'b0; m_led = ~m_led;
    end else if (b == 8'h54) begin
      m_in_addr = 1'b1;
      m_bytes.delete();
    end else begin
      k = K_CERR;
    end
    push_win(mid, k);
  endfunction

  function automatic void model_timeout(input int mid);
    m_in_addr = 1'b0;
    m_bytes.delete();
    push_win(mid + TMO, K_CERR);
  endfunction

  function automatic void model_reset();
    m_addr = 32'h0; m_en = 1'b0; m_led = 1'b0; m_in_addr = 1'b0;
    m_bytes.delete();
    win_q.delete();
    c_addr = 32'h0; c_en = 1'b0; c_led = 1'b0;
    win_hits = 0;
  endfunction

  task automatic tick();
    @(posedge serial_clock);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input bit stop_ok, input bit modeled);
    pin_usart_rx = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      pin_usart_rx = b[i];
      repeat (CPB) tick();
    end
    pin_usart_rx = stop_ok;
    last_mid = cyc + CPB / 2;
    if (modeled) model_byte(b, stop_ok, last_mid);
    repeat (CPB) tick();
    pin_usart_rx = 1'b1;
  endtask

  // Per-cycle compare against the model.
  always @(negedge serial_clock) begin
    logic [3:0] pv;
    if (reset) begin
      pv = {dump_start, record_start, frame_error, cmd_error};
      if (win_q.size() > 0 && cyc >= win_q[0].lo) begin
        if (pv != 4'b0000) begin
          check("pulse_kind", 32'(pv), 32'(win_q[0].mask));
          if (pv == win_q[0].mask) win_hits++;
        end
        if (cyc >= win_q[0].hi) begin
          check("pulse_count", 32'(win_hits), (win_q[0].mask != K_NONE) ? 32'd1 : 32'd0);
          c_addr = win_q[0].addr;
          c_en   = win_q[0].en;
          c_led  = win_q[0].led;
          void'(win_q.pop_front());
          win_hits = 0;
        end
      end else begin
        check("quiet_pulses", 32'(pv), 32'd0);
        check("trigger_addr", trigger_addr, c_addr);
        check("trigger_enable", 32'(trigger_enable), 32'(c_en));
        check("led", 32'(led), 32'(c_led));
      end
    end
  end

  initial begin
    repeat (3) tick();
    check("rst_addr", trigger_addr, 32'h0);
    check("rst_en", 32'(trigger_enable), 32'd0);
    check("rst_led", 32'(led), 32'd0);
    check("rst_pulses", 32'({dump_start, record_start, frame_error, cmd_error}), 32'd0);
    reset = 1'b1;
    repeat (10) tick();

    send(8'h44, 1'b1, 1'b1);
    repeat (20) tick();
    check("D_led", 32'(led), 32'd1);

    send(8'h54, 1'b1, 1'b1);
    send(8'h12, 1'b1, 1'b1);
    send(8'h34, 1'b1, 1'b1);
    send(8'h56, 1'b1, 1'b1);
    check("T_partial_addr", trigger_addr, 32'h0);
    check("T_partial_en", 32'(trigger_enable), 32'd0);
    send(8'h78, 1'b1, 1'b1);
    repeat (20) tick();
    check("T_addr", trigger_addr, 32'h12345678);
    check("T_en", 32'(trigger_enable), 32'd1);
    check("T_led", 32'(led), 32'd0);

    send(8'h43, 1'b1, 1'b1);
    repeat (20) tick();
    check("C_en", 32'(trigger_enable), 32'd0);
    check("C_addr", trigger_addr, 32'h12345678);
    check("C_led", 32'(led), 32'd1);

    send(8'h44, 1'b0, 1'b1);
    repeat (64) tick();
    check("ferr_led", 32'(led), 32'd1);

    pin_usart_rx = 1'b0;
    repeat (10) tick();
    pin_usart_rx = 1'b1;
    repeat (40) tick();
    send(8'h52, 1'b1, 1'b1);
    repeat (20) tick();
    check("R_led", 32'(led), 32'd0);

    send(8'h54, 1'b1, 1'b1);
    send(8'h12, 1'b1, 1'b1);
    send(8'h34, 1'b1, 1'b1);
    fork
      send(8'hF0, 1'b1, 1'b0);
      begin
        repeat (80) tick();
        reset = 1'b0;
        model_reset();
        repeat (96) tick();
        reset = 1'b1;
      end
    join
    repeat (20) tick();
    check("rstmid_addr", trigger_addr, 32'h0);
    check("rstmid_en", 32'(trigger_enable), 32'd0);
    check("rstmid_led", 32'(led), 32'd0);

    send(8'h54, 1'b1, 1'b1);
    send(8'hAA, 1'b1, 1'b1);
    model_timeout(last_mid);
    repeat (TMO + 40) tick();
    send(8'h44, 1'b1, 1'b1);
    repeat (20) tick();
    check("tmo_addr", trigger_addr, 32'h0);
    check("tmo_en", 32'(trigger_enable), 32'd0);
    check("tmo_led", 32'(led), 32'd1);

    send(8'h54, 1'b1, 1'b1);
    send(8'h01, 1'b1, 1'b1);
    send(8'h02, 1'b0, 1'b1);
    repeat (64) tick();
    send(8'h44, 1'b1, 1'b1);
    repeat (20) tick();
    check("addrferr_led", 32'(led), 32'd0);
    check("addrferr_addr", trigger_addr, 32'h0);

    send(8'h5A, 1'b1, 1'b1);
    repeat (20) tick();
    check("unknown_led", 32'(led), 32'd0);

    repeat (20) tick();
    check("windows_drained", 32'(win_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
